// File: rtl/fsm_counter_scheduler.sv
// Round-robin job scheduler that hands one requester's count to a shared counter,
// waits for completion or a watchdog timeout, then reports back to the owner.
module fsm_counter_scheduler #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned CNT_BW      = 7,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*CNT_BW-1:0] i_req_num_cnt,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [NUM_REQ-1:0]        o_job_done,
    output logic                      o_timeout,
    output logic                      o_cnt_run,
    output logic [CNT_BW-1:0]         o_cnt_num_cnt,
    input  logic                      i_cnt_idle,
    input  logic                      i_cnt_done,
    output logic                      o_busy,
    output logic [1:0]                o_cur_id
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t              state;
    logic [1:0]          last_id;
    logic [7:0]          wdog;
    logic                timeout_flag;
    logic                grant_hit;
    logic [1:0]          grant_id;
    logic [CNT_BW-1:0]   grant_cnt;

    // Search begins just after the last served requester, so it is visited last.
    always_comb begin
        grant_hit = 1'b0;
        grant_id  = last_id;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!grant_hit && i_req_valid[last_id + 2'(i)]) begin
                grant_hit = 1'b1;
                grant_id  = last_id + 2'(i);
            end
        end
        grant_cnt = i_req_num_cnt[grant_id*CNT_BW +: CNT_BW];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            last_id       <= 2'd3;
            wdog          <= '0;
            timeout_flag  <= 1'b0;
            o_req_ready   <= '0;
            o_job_done    <= '0;
            o_timeout     <= 1'b0;
            o_cnt_run     <= 1'b0;
            o_cnt_num_cnt <= '0;
            o_busy        <= 1'b0;
            o_cur_id      <= '0;
        end else begin
            o_req_ready <= '0;
            o_job_done  <= '0;
            o_timeout   <= 1'b0;
            o_cnt_run   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_hit && i_cnt_idle) begin
                        o_req_ready   <= NUM_REQ'(1) << grant_id;
                        o_cur_id      <= grant_id;
                        o_cnt_num_cnt <= grant_cnt;
                        o_busy        <= 1'b1;
                        state         <= (grant_cnt == '0) ? DONE : ISSUE;
                    end
                end
                ISSUE: begin
                    o_cnt_run <= 1'b1;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (i_cnt_done) begin
                        state <= DONE;
                    end else if (wdog == 8'(TIMEOUT_CYC - 1)) begin
                        // The WAIT cycle that would bring the watchdog to TIMEOUT_CYC ends the job.
                        timeout_flag <= 1'b1;
                        state        <= DONE;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
                end
                DONE: begin
                    o_job_done   <= NUM_REQ'(1) << o_cur_id;
                    o_timeout    <= timeout_flag;
                    timeout_flag <= 1'b0;
                    wdog         <= '0;
                    last_id      <= o_cur_id;
                    o_busy       <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
